// File: rtl/nmi2apb_bridge.sv
// nmi2apb_bridge: single-outstanding NMI-to-APB bridge with sticky error capture.
// Define NMI2APB_TIMEOUT_EN to force completion after TMO_CYC ACCESS cycles without pready_i.
module nmi2apb_bridge #(
    parameter int unsigned APB_AW  = 16,
    parameter int unsigned TMO_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              nmi_valid_i,
    input  logic [31:0]       nmi_addr_i,
    input  logic [31:0]       nmi_wdata_i,
    input  logic [3:0]        nmi_wstrb_i,
    output logic              nmi_ready_o,
    output logic [31:0]       nmi_rdata_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [APB_AW-1:0] paddr_o,
    output logic [31:0]       pwdata_o,
    output logic [3:0]        pstrb_o,
    input  logic [31:0]       prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i,
    output logic              err_o,
    output logic [31:0]       err_addr_o,
    input  logic              err_clr_i
);
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;
    localparam logic [DW-1:0] TMO_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [DW-1:0] addr_q;
    logic          capture;
    logic          err_evt;
    logic          tmo_hit;
    logic [DW-1:0] rdata_d;
    logic          psel_d;
    logic          penable_d;
    logic          ready_d;

    assign paddr_o = addr_q[APB_AW-1:0];

`ifdef NMI2APB_TIMEOUT_EN
    logic [CW-1:0] tmo_cnt_q;

    // Counts ACCESS cycles; zero on every ACCESS entry, fires on the TMO_CYC-th cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
        end else if (state_q != ACCESS) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + CW'(1);
        end
    end

    assign tmo_hit = (state_q == ACCESS) && (tmo_cnt_q == CW'(TMO_CYC - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO_CYC;
    assign tmo_hit    = 1'b0;
`endif

    // Next state plus the next value of every registered output.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        err_evt = 1'b0;
        rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (nmi_valid_i) begin
                    state_d = SETUP;
                    capture = 1'b1;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // A completer response on the timeout cycle still counts as a normal finish.
                if (pready_i) begin
                    state_d = DONE;
                    err_evt = pslverr_i;
                    rdata_d = (pslverr_i || pwrite_o) ? '0 : prdata_i;
                end else if (tmo_hit) begin
                    state_d = DONE;
                    err_evt = 1'b1;
                    rdata_d = pwrite_o ? '0 : TMO_DATA;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        psel_d    = (state_d == SETUP) || (state_d == ACCESS);
        penable_d = (state_d == ACCESS);
        ready_d   = (state_d == DONE);
    end

    // State register and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            pwdata_o    <= '0;
            pstrb_o     <= '0;
            pwrite_o    <= 1'b0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            nmi_ready_o <= 1'b0;
            nmi_rdata_o <= '0;
            err_o       <= 1'b0;
            err_addr_o  <= '0;
        end else begin
            state_q     <= state_d;
            psel_o      <= psel_d;
            penable_o   <= penable_d;
            nmi_ready_o <= ready_d;
            nmi_rdata_o <= rdata_d;
            if (capture) begin
                addr_q   <= nmi_addr_i;
                pwdata_o <= nmi_wdata_i;
                pstrb_o  <= nmi_wstrb_i;
                pwrite_o <= |nmi_wstrb_i;
            end
            // Clear beats a coincident error; only the first error's address is kept.
            if (err_clr_i) begin
                err_o      <= 1'b0;
                err_addr_o <= '0;
            end else if (err_evt && !err_o) begin
                err_o      <= 1'b1;
                err_addr_o <= addr_q;
            end
        end
    end

endmodule

// File: tb/tb_nmi2apb_bridge.sv
// Directed self-checking bench for nmi2apb_bridge; timeout scenario runs when NMI2APB_TIMEOUT_EN is defined.
module tb_nmi2apb_bridge;
    localparam int unsigned APB_AW  = 16;
    localparam int unsigned TMO_CYC = 8;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              nmi_valid_i = 1'b0;
    logic [31:0]       nmi_addr_i = '0;
    logic [31:0]       nmi_wdata_i = '0;
    logic [3:0]        nmi_wstrb_i = '0;
    logic              nmi_ready_o;
    logic [31:0]       nmi_rdata_o;
    logic              psel_o;
    logic              penable_o;
    logic              pwrite_o;
    logic [APB_AW-1:0] paddr_o;
    logic [31:0]       pwdata_o;
    logic [3:0]        pstrb_o;
    logic [31:0]       prdata_i = '0;
    logic              pready_i = 1'b0;
    logic              pslverr_i = 1'b0;
    logic              err_o;
    logic [31:0]       err_addr_o;
    logic              err_clr_i = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        int          setup_at;
        int          sel_cyc;
        int          setups;
        logic        stable;
        logic [15:0] paddr;
        logic        pwrite;
        logic [3:0]  pstrb;
        logic [31:0] pwdata;
    } obs_t;

    nmi2apb_bridge #(.APB_AW(APB_AW), .TMO_CYC(TMO_CYC)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .nmi_valid_i(nmi_valid_i), .nmi_addr_i(nmi_addr_i), .nmi_wdata_i(nmi_wdata_i),
        .nmi_wstrb_i(nmi_wstrb_i), .nmi_ready_o(nmi_ready_o), .nmi_rdata_o(nmi_rdata_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
        .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .prdata_i(prdata_i), .pready_i(pready_i),
        .pslverr_i(pslverr_i), .err_o(err_o), .err_addr_o(err_addr_o), .err_clr_i(err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected normal finish");
        $fatal(1, "watchdog");
    end

    // Advance to 1ns after the next rising edge: drive and sample point of a cycle.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Issue one request in the current (IDLE) cycle N; completer inserts `waits` wait states.
    task automatic run_xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                            input int waits, input logic [31:0] rd, input logic slv,
                            input logic clr, output obs_t o);
        int acc;
        acc = 0;
        o.lat = -1; o.rdata = '0; o.setup_at = -1; o.sel_cyc = 0; o.setups = 0;
        o.stable = 1'b1; o.paddr = '0; o.pwrite = 1'b0; o.pstrb = '0; o.pwdata = '0;
        nmi_addr_i = a; nmi_wdata_i = wd; nmi_wstrb_i = ws; nmi_valid_i = 1'b1; prdata_i = rd;
        for (int c = 1; c <= 60; c++) begin
            step();
            if (c == 1) begin
                nmi_addr_i = ~a; nmi_wdata_i = ~wd; nmi_wstrb_i = ~ws;
            end
            pready_i = 1'b0; pslverr_i = 1'b0; err_clr_i = 1'b0;
            if (nmi_ready_o) begin
                o.lat = c; o.rdata = nmi_rdata_o;
                break;
            end
            if (psel_o) begin
                o.sel_cyc++;
                if (o.sel_cyc == 1) begin
                    o.paddr = paddr_o; o.pwrite = pwrite_o; o.pstrb = pstrb_o; o.pwdata = pwdata_o;
                end else if (paddr_o !== o.paddr || pwrite_o !== o.pwrite ||
                             pstrb_o !== o.pstrb || pwdata_o !== o.pwdata) begin
                    o.stable = 1'b0;
                end
                if (!penable_o) begin
                    o.setups++;
                    if (o.setup_at < 0) o.setup_at = c;
                end else begin
                    pready_i  = (acc >= waits);
                    pslverr_i = slv & pready_i;
                    err_clr_i = clr & pready_i;
                    acc++;
                end
            end
        end
        nmi_valid_i = 1'b0; pready_i = 1'b0; pslverr_i = 1'b0; err_clr_i = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        n_tests++; if (psel_o !== 1'b0 || penable_o !== 1'b0 || pwrite_o !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: got sel=%b en=%b wr=%b expected 0 0 0", psel_o, penable_o, pwrite_o); end
        n_tests++; if (paddr_o !== 16'h0 || pwdata_o !== 32'h0 || pstrb_o !== 4'h0) begin n_fail++; $display("FAIL reset_bus: got addr=%h wdata=%h strb=%h expected zeros", paddr_o, pwdata_o, pstrb_o); end
        n_tests++; if (nmi_ready_o !== 1'b0 || nmi_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_nmi: got ready=%b rdata=%h expected 0 0", nmi_ready_o, nmi_rdata_o); end
        n_tests++; if (err_o !== 1'b0 || err_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_err: got err=%b addr=%h expected 0 0", err_o, err_addr_o); end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_read();
        obs_t o;
        run_xfer(32'h0000_1004, 32'h0, 4'h0, 0, 32'h1234_5678, 1'b0, 1'b0, o);
        n_tests++; if (o.lat !== 3) begin n_fail++; $display("FAIL read_latency: got %0d expected 3", o.lat); end
        n_tests++; if (o.setup_at !== 1 || o.setups !== 1) begin n_fail++; $display("FAIL read_setup: got at=%0d count=%0d expected 1 1", o.setup_at, o.setups); end
        n_tests++; if (o.rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL read_data: got %h expected 12345678", o.rdata); end
        n_tests++; if (o.paddr !== 16'h1004 || o.pwrite !== 1'b0) begin n_fail++; $display("FAIL read_apb: got addr=%h wr=%b expected 1004 0", o.paddr, o.pwrite); end
        n_tests++; if (o.stable !== 1'b1) begin n_fail++; $display("FAIL read_stable: got %b expected 1", o.stable); end
        n_tests++; if (nmi_ready_o !== 1'b0 || nmi_rdata_o !== 32'h0) begin n_fail++; $display("FAIL read_after: got ready=%b rdata=%h expected 0 0", nmi_ready_o, nmi_rdata_o); end
    endtask

    task automatic test_write();
        obs_t o;
        run_xfer(32'h0000_0040, 32'hAABB_CCDD, 4'b0011, 2, 32'hFFFF_FFFF, 1'b0, 1'b0, o);
        n_tests++; if (o.lat !== 5) begin n_fail++; $display("FAIL write_latency: got %0d expected 5", o.lat); end
        n_tests++; if (o.rdata !== 32'h0) begin n_fail++; $display("FAIL write_rdata: got %h expected 0", o.rdata); end
        n_tests++; if (o.pwrite !== 1'b1 || o.pstrb !== 4'b0011 || o.pwdata !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL write_apb: got wr=%b strb=%b wdata=%h expected 1 0011 aabbccdd", o.pwrite, o.pstrb, o.pwdata); end
        n_tests++; if (o.sel_cyc !== 4 || o.stable !== 1'b1) begin n_fail++; $display("FAIL write_stable: got cycles=%0d stable=%b expected 4 1", o.sel_cyc, o.stable); end
    endtask

    task automatic test_errors();
        obs_t o;
        run_xfer(32'h0000_2000, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b1, 1'b0, o);
        n_tests++; if (o.lat !== 3 || o.rdata !== 32'h0) begin n_fail++; $display("FAIL err1_xfer: got lat=%0d rdata=%h expected 3 0", o.lat, o.rdata); end
        n_tests++; if (err_o !== 1'b1 || err_addr_o !== 32'h0000_2000) begin n_fail++; $display("FAIL err1_flag: got err=%b addr=%h expected 1 00002000", err_o, err_addr_o); end
        run_xfer(32'h0000_3000, 32'h0, 4'h0, 1, 32'h1111_2222, 1'b1, 1'b0, o);
        n_tests++; if (err_o !== 1'b1 || err_addr_o !== 32'h0000_2000) begin n_fail++; $display("FAIL err2_keep: got err=%b addr=%h expected 1 00002000", err_o, err_addr_o); end
        run_xfer(32'h0000_3800, 32'h0, 4'h0, 0, 32'h3333_4444, 1'b1, 1'b1, o);
        n_tests++; if (o.lat !== 3 || err_o !== 1'b0 || err_addr_o !== 32'h0) begin n_fail++; $display("FAIL err3_clr: got lat=%0d err=%b addr=%h expected 3 0 0", o.lat, err_o, err_addr_o); end
        run_xfer(32'h0000_4000, 32'h5555_6666, 4'hF, 0, 32'h7777_8888, 1'b1, 1'b0, o);
        n_tests++; if (err_o !== 1'b1 || err_addr_o !== 32'h0000_4000 || o.rdata !== 32'h0) begin n_fail++; $display("FAIL err4_reload: got err=%b addr=%h rdata=%h expected 1 00004000 0", err_o, err_addr_o, o.rdata); end
    endtask

    task automatic test_back_to_back();
        int setup_at[$];
        int rdy;
        int extra;
        rdy = 0; extra = 0;
        nmi_addr_i = 32'h0000_0100; nmi_wdata_i = 32'h0BAD_0001; nmi_wstrb_i = 4'hF;
        nmi_valid_i = 1'b1; pready_i = 1'b1;
        for (int c = 1; c <= 30 && rdy < 3; c++) begin
            step();
            if (psel_o && !penable_o) setup_at.push_back(c);
            if (nmi_ready_o) begin
                rdy++;
                nmi_addr_i = nmi_addr_i + 32'h100;
                if (rdy == 3) nmi_valid_i = 1'b0;
            end
        end
        for (int c = 0; c < 6; c++) begin
            step();
            if (psel_o && !penable_o) extra++;
        end
        pready_i = 1'b0;
        n_tests++; if (rdy !== 3) begin n_fail++; $display("FAIL b2b_ready: got %0d pulses expected 3", rdy); end
        n_tests++; if (setup_at.size() != 3 || setup_at[0] != 1 || setup_at[1] != 5 || setup_at[2] != 9) begin n_fail++; $display("FAIL b2b_spacing: got %0d setups expected 3 at cycles 1 5 9", setup_at.size()); end
        n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL b2b_duplicate: got %0d extra setups expected 0", extra); end
    endtask

    task automatic test_reset_abort();
        obs_t o;
        int seen;
        seen = 0;
        nmi_addr_i = 32'h0000_5000; nmi_wstrb_i = 4'h0; nmi_valid_i = 1'b1; pready_i = 1'b0;
        step();
        step();
        n_tests++; if (psel_o !== 1'b1 || penable_o !== 1'b1) begin n_fail++; $display("FAIL abort_pre: got sel=%b en=%b expected 1 1", psel_o, penable_o); end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0; nmi_valid_i = 1'b0;
        n_tests++; if (psel_o !== 1'b0 || penable_o !== 1'b0 || nmi_ready_o !== 1'b0) begin n_fail++; $display("FAIL abort_clear: got sel=%b en=%b ready=%b expected 0 0 0", psel_o, penable_o, nmi_ready_o); end
        for (int c = 0; c < 5; c++) begin
            step();
            if (nmi_ready_o || psel_o) seen++;
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL abort_quiet: got %0d active cycles expected 0", seen); end
        run_xfer(32'h0000_6008, 32'h0, 4'h0, 1, 32'h0BAD_F00D, 1'b0, 1'b0, o);
        n_tests++; if (o.lat !== 4 || o.rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL abort_recover: got lat=%0d rdata=%h expected 4 0badf00d", o.lat, o.rdata); end
    endtask

`ifdef NMI2APB_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        run_xfer(32'h0000_7000, 32'h0, 4'h0, 1000, 32'h9999_AAAA, 1'b0, 1'b0, o);
        n_tests++; if (o.lat !== 10 || o.rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL tmo_hit: got lat=%0d rdata=%h expected 10 deadbeef", o.lat, o.rdata); end
        n_tests++; if (err_o !== 1'b1 || err_addr_o !== 32'h0000_7000) begin n_fail++; $display("FAIL tmo_err: got err=%b addr=%h expected 1 00007000", err_o, err_addr_o); end
        run_xfer(32'h0000_7100, 32'h0, 4'h0, 7, 32'h55AA_33CC, 1'b0, 1'b0, o);
        n_tests++; if (o.lat !== 10 || o.rdata !== 32'h55AA_33CC) begin n_fail++; $display("FAIL tmo_edge: got lat=%0d rdata=%h expected 10 55aa33cc", o.lat, o.rdata); end
        n_tests++; if (err_o !== 1'b1 || err_addr_o !== 32'h0000_7000) begin n_fail++; $display("FAIL tmo_edge_err: got err=%b addr=%h expected 1 00007000", err_o, err_addr_o); end
    endtask
`else
    task automatic test_long_wait();
        obs_t o;
        run_xfer(32'h0000_7000, 32'h0, 4'h0, 30, 32'h9999_AAAA, 1'b0, 1'b0, o);
        n_tests++; if (o.lat !== 33 || o.rdata !== 32'h9999_AAAA) begin n_fail++; $display("FAIL long_wait: got lat=%0d rdata=%h expected 33 9999aaaa", o.lat, o.rdata); end
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL long_wait_err: got err=%b expected 0", err_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_errors();
        test_back_to_back();
        test_reset_abort();
`ifdef NMI2APB_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
